relu_act_serializer: RTL
========================

// Module: relu_act_serializer
// PURPOSE
// - Consumer at the output end of the 4-lane ReLU stage.
// - Detects the ReLU ready rising edge and captures the four activations into a frame buffer.
// - Rescales and saturates each activation, then streams them one per handshake (valid/ready) to the next layer's input.
// - Absorbs the ReLU's lack of backpressure and flags frames it could not accept.
// PARAMETERS
// - IN_W    12  width of signed ReLU activations act0..act3
// - OUT_W   8   width of signed serialized activation act_out
// - SHIFT   4   arithmetic right shift applied before saturation (fixed-point rescale)
// PORTS
// - clk         in   1      single clock, rising edge
// - rst         in   1      synchronous, active-high reset
// - relu_ready  in   1      ReLU output_ready, level signal
// - act0..act3  in   IN_W   signed ReLU outputs, lanes 0..3
// - act_out     out  OUT_W  signed rescaled activation
// - act_idx     out  2      lane index of act_out
// - act_valid   out  1      act_out/act_idx valid
// - act_ready   in   1      downstream accepts when act_valid & act_ready
// - frame_last  out  1      high with act_valid when act_idx==3
// - frame_done  out  1      one-cycle pulse after lane 3 handshake
// - busy        out  1      frame held (state SEND)
// - overrun     out  1      sticky: a ReLU frame arrived while busy
// BEHAVIOUR
// - Reset: state=IDLE; act_out=0, act_idx=0, act_valid=0, frame_last=0, frame_done=0, busy=0, overrun=0; buffer=0; relu_ready_q=0.
// - Because relu_ready_q resets to 0, a relu_ready already high when reset is released counts as one edge.
// - Edge detection: relu_ready_q <= relu_ready each cycle. cap_edge = relu_ready & ~relu_ready_q.
// - Per-lane arithmetic, computed at capture:
//   - v = (act<0) ? 0 : act  (defensive clamp)
//   - s = v >>> SHIFT
//   - out = (s > 2^(OUT_W-1)-1) ? 2^(OUT_W-1)-1 : s[OUT_W-1:0]
//   - Output is never negative.
// - IDLE:
//   - If cap_edge in cycle N: latch 4 results and set idx=0 at the end of N, go to SEND.
//   - act_valid=1 from cycle N+1 (1-cycle latency).
// - SEND:
//   - act_valid=1, act_out=buf[idx], act_idx=idx, busy=1, frame_last=(idx==3).
//   - act_out/act_idx hold stable while act_valid & ~act_ready.
//   - Handshake with idx<3: idx++. Back-to-back handshakes give one lane per cycle.
//   - Handshake with idx==3: go to IDLE, act_valid=0 and frame_done=1 in the next cycle.
//   - Minimum frame is 4 cycles, plus 1 capture cycle.
// - Overrun:
//   - cap_edge while in SEND, including the cycle of the lane-3 handshake, sets overrun=1.
//   - That frame is dropped. The buffer and the current stream are unaffected.
//   - overrun clears only on rst.
// - relu_ready held high: captures once only. A new frame needs relu_ready to fall and rise again.
// - Reset mid-stream: the frame is abandoned, and act_valid=0 in the cycle after rst is sampled.
// - act_ready is ignored in IDLE. act_valid never drops before its handshake.
// TESTING
// - Capture/scale: SHIFT=4, act={100,0,2047,16}, rising relu_ready, act_ready=1 -> act_out 6,0,127,1 with idx 0..3 on consecutive cycles starting 1 cycle after the edge; frame_done pulses once.
// - Saturation/clamp: SHIFT=0, act={300,-5,127,128} -> 127,0,127,127.
// - Backpressure: act_ready=0 for 3 cycles at idx=1 -> act_out/act_idx stable, valid held; resumes at idx=1 with no lane lost or repeated.
// - Overrun: second relu_ready rising edge during idx=2 -> first frame completes unchanged; overrun=1 sticky; no second frame streamed.
// - Level hold: relu_ready high for 20 cycles -> exactly one frame; toggling low then high -> second frame.
// - Reset mid-frame: rst at idx=2 -> next cycle act_valid=0, overrun=0, busy=0; new edge streams a fresh frame from idx 0.

Source files
------------

// File: rtl/relu_act_serializer_if.sv
// -----------------------------------------------------------------------------
// relu_act_serializer_if
// Purpose : valid/ready stream that carries one rescaled activation at a time
//           from the ReLU serializer to the next layer's input.
// Signals :
//   act_out    signed activation (OUT_W bits), driven by the master
//   act_idx    lane index of act_out (0..3), driven by the master
//   act_valid  act_out/act_idx valid, driven by the master
//   frame_last high with act_valid on lane 3, driven by the master
//   act_ready  sink accepts when act_valid & act_ready, driven by the slave
// -----------------------------------------------------------------------------
interface relu_act_serializer_if #(
   parameter int OUT_W = 8
) ();
   logic signed [OUT_W-1:0] act_out;
   logic [1:0]              act_idx;
   logic                    act_valid;
   logic                    act_ready;
   logic                    frame_last;

   modport master (
      output act_out,
      output act_idx,
      output act_valid,
      output frame_last,
      input  act_ready
   );

   modport slave (
      input  act_out,
      input  act_idx,
      input  act_valid,
      input  frame_last,
      output act_ready
   );
endinterface

// File: rtl/relu_act_serializer.sv
// -----------------------------------------------------------------------------
// relu_act_serializer
// Purpose : Sits at the output of the 4-lane ReLU stage. On a rising edge of
//           relu_ready the four activations are clamped at zero, shifted right
//           by SHIFT, saturated to OUT_W signed bits and held in a frame
//           buffer. The buffer is then streamed one lane per valid/ready
//           handshake. The ReLU cannot be stalled, so a frame that arrives
//           while a previous one is still streaming is dropped and flagged.
// Ports   :
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   relu_ready  ReLU output_ready level; its rising edge triggers a capture
//   act0..act3  signed ReLU activations (IN_W bits), lanes 0..3
//   act_if      master side of the activation stream (act_out, act_idx,
//               act_valid, frame_last out; act_ready in)
//   frame_done  one-cycle pulse after the lane-3 handshake
//   busy        high while a frame is held for streaming
//   overrun     sticky flag: a ReLU frame arrived while busy (cleared by rst)
// -----------------------------------------------------------------------------
module relu_act_serializer #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 8,
   parameter int SHIFT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   relu_ready,
   input  logic signed [IN_W-1:0] act0,
   input  logic signed [IN_W-1:0] act1,
   input  logic signed [IN_W-1:0] act2,
   input  logic signed [IN_W-1:0] act3,
   relu_act_serializer_if.master  act_if,
   output logic                   frame_done,
   output logic                   busy,
   output logic                   overrun
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Largest positive OUT_W-bit value, widened to IN_W bits for comparison.
   localparam logic [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

   // Clamp negatives to zero, rescale, then saturate to the positive OUT_W range.
   function automatic logic [OUT_W-1:0] rescale(input logic signed [IN_W-1:0] a);
      logic [IN_W-1:0] v;
      logic [IN_W-1:0] s;
      if (a[IN_W-1]) begin
         v = '0;
      end else begin
         v = a;
      end
      // v is non-negative, so a logical shift equals the arithmetic shift.
      s = v >> SHIFT;
      if (s > SAT_MAX) begin
         rescale = SAT_MAX[OUT_W-1:0];
      end else begin
         rescale = s[OUT_W-1:0];
      end
   endfunction

   state_t           state_r;
   logic             relu_ready_q_r;
   logic [OUT_W-1:0] frame_buf_r [4];
   logic [OUT_W-1:0] act_out_r;
   logic [1:0]       act_idx_r;
   logic             act_valid_r;
   logic             frame_last_r;
   logic             frame_done_r;
   logic             busy_r;
   logic             overrun_r;

   logic             cap_edge_s;
   logic [1:0]       nxt_idx_s;
   logic [OUT_W-1:0] lane_s [4];

   assign cap_edge_s = relu_ready & ~relu_ready_q_r;
   assign nxt_idx_s  = act_idx_r + 2'd1;

   // Rescaled value of each live ReLU lane, used only at capture time.
   always_comb begin
      lane_s[0] = rescale(act0);
      lane_s[1] = rescale(act1);
      lane_s[2] = rescale(act2);
      lane_s[3] = rescale(act3);
   end

   // Capture/stream FSM with registered stream and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         relu_ready_q_r <= 1'b0;
         act_out_r      <= '0;
         act_idx_r      <= 2'd0;
         act_valid_r    <= 1'b0;
         frame_last_r   <= 1'b0;
         frame_done_r   <= 1'b0;
         busy_r         <= 1'b0;
         overrun_r      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            frame_buf_r[i] <= '0;
         end
      end else begin
         relu_ready_q_r <= relu_ready;
         frame_done_r   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cap_edge_s) begin
                  for (int i = 0; i < 4; i++) begin
                     frame_buf_r[i] <= lane_s[i];
                  end
                  // Lane 0 is presented straight away: valid one cycle after the edge.
                  act_out_r    <= lane_s[0];
                  act_idx_r    <= 2'd0;
                  act_valid_r  <= 1'b1;
                  frame_last_r <= 1'b0;
                  busy_r       <= 1'b1;
                  state_r      <= ST_SEND;
               end else begin
                  act_valid_r  <= 1'b0;
                  frame_last_r <= 1'b0;
                  busy_r       <= 1'b0;
               end
            end
            ST_SEND: begin
               // A new frame cannot be held while streaming; drop it and flag.
               if (cap_edge_s) begin
                  overrun_r <= 1'b1;
               end else begin
                  overrun_r <= overrun_r;
               end
               // act_valid is always high in SEND, so act_ready alone is the handshake.
               if (act_if.act_ready) begin
                  if (act_idx_r == 2'd3) begin
                     act_valid_r  <= 1'b0;
                     frame_last_r <= 1'b0;
                     busy_r       <= 1'b0;
                     frame_done_r <= 1'b1;
                     state_r      <= ST_IDLE;
                  end else begin
                     act_idx_r    <= nxt_idx_s;
                     act_out_r    <= frame_buf_r[nxt_idx_s];
                     frame_last_r <= (nxt_idx_s == 2'd3);
                  end
               end else begin
                  act_idx_r <= act_idx_r;
                  act_out_r <= act_out_r;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               act_valid_r  <= 1'b0;
               frame_last_r <= 1'b0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   assign act_if.act_out    = act_out_r;
   assign act_if.act_idx    = act_idx_r;
   assign act_if.act_valid  = act_valid_r;
   assign act_if.frame_last = frame_last_r;
   assign frame_done        = frame_done_r;
   assign busy              = busy_r;
   assign overrun           = overrun_r;

endmodule
